// File: rtl/operand_loader.sv
// Byte-serial operand entry for the 32-bit add/sub stage.
// Two debounced buttons step bytes into two registered operands.
module operand_loader #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int CNT_W           = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  sw,
    input  logic        btn_load,
    input  logic        btn_clear,
    output logic [31:0] operand1,
    output logic [31:0] operand2,
    output logic [1:0]  counter,
    output logic        fstorsnd,
    output logic        done,
    output logic        load_ack
);

    localparam logic [1:0] S_LOAD_A = 2'd0;
    localparam logic [1:0] S_LOAD_B = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Bit 0 = load button, bit 1 = clear button.
    logic [1:0]            sync1_q;
    logic [1:0]            sync2_q;
    logic [1:0]            db_q;
    logic [1:0]            db_prev_q;
    logic [1:0][CNT_W-1:0] dcnt_q;

    logic load_p;
    logic clear_p;

    logic [1:0]  state_q, state_d;
    logic [31:0] op1_q, op1_d;
    logic [31:0] op2_q, op2_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        fst_q, fst_d;
    logic        done_q, done_d;
    logic        ack_q, ack_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            db_q      <= '0;
            db_prev_q <= '0;
            dcnt_q    <= '0;
        end else begin
            sync1_q   <= {btn_clear, btn_load};
            sync2_q   <= sync1_q;
            db_prev_q <= db_q;
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] == db_q[i]) begin
                    dcnt_q[i] <= '0;
                end else if (dcnt_q[i] == CNT_LAST) begin
                    db_q[i]   <= sync2_q[i];
                    dcnt_q[i] <= '0;
                end else begin
                    dcnt_q[i] <= dcnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign load_p  = db_q[0] & ~db_prev_q[0];
    assign clear_p = db_q[1] & ~db_prev_q[1];

    always_comb begin
        state_d = state_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        cnt_d   = cnt_q;
        fst_d   = fst_q;
        done_d  = done_q;
        ack_d   = 1'b0;
        if (clear_p) begin
            state_d = S_LOAD_A;
            op1_d   = '0;
            op2_d   = '0;
            cnt_d   = '0;
            fst_d   = 1'b0;
            done_d  = 1'b0;
        end else if (load_p && (state_q == S_LOAD_A)) begin
            op1_d[{cnt_q, 3'b000} +: 8] = sw;
            cnt_d = cnt_q + 1'b1;
            ack_d = 1'b1;
            if (cnt_q == 2'd3) begin
                fst_d   = 1'b1;
                state_d = S_LOAD_B;
            end
        end else if (load_p && (state_q == S_LOAD_B)) begin
            op2_d[{cnt_q, 3'b000} +: 8] = sw;
            cnt_d = cnt_q + 1'b1;
            ack_d = 1'b1;
            if (cnt_q == 2'd3) begin
                done_d  = 1'b1;
                state_d = S_DONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_LOAD_A;
            op1_q   <= '0;
            op2_q   <= '0;
            cnt_q   <= '0;
            fst_q   <= 1'b0;
            done_q  <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            cnt_q   <= cnt_d;
            fst_q   <= fst_d;
            done_q  <= done_d;
            ack_q   <= ack_d;
        end
    end

    assign operand1 = op1_q;
    assign operand2 = op2_q;
    assign counter  = cnt_q;
    assign fstorsnd = fst_q;
    assign done     = done_q;
    assign load_ack = ack_q;

endmodule

// File: tb/tb_operand_loader.sv
// Directed and random byte entry for operand_loader,
// checked against a byte-list model of the two operands.
module tb_operand_loader;

    localparam int DC  = 4;
    localparam int LAT = 2 + DC + 1;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  sw;
    logic        btn_load;
    logic        btn_clear;
    logic [31:0] operand1;
    logic [31:0] operand2;
    logic [1:0]  counter;
    logic        fstorsnd;
    logic        done;
    logic        load_ack;

    int checks   = 0;
    int failures = 0;
    int acks     = 0;

    logic [7:0] mb [8];
    int         idx;

    operand_loader #(
        .DEBOUNCE_CYCLES(DC),
        .CNT_W(20)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sw(sw),
        .btn_load(btn_load),
        .btn_clear(btn_clear),
        .operand1(operand1),
        .operand2(operand2),
        .counter(counter),
        .fstorsnd(fstorsnd),
        .done(done),
        .load_ack(load_ack)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (load_ack === 1'b1) acks++;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 8; i++) mb[i] = 8'h00;
        idx = 0;
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".op1"}, operand1, {mb[3], mb[2], mb[1], mb[0]});
        chk({tag, ".op2"}, operand2, {mb[7], mb[6], mb[5], mb[4]});
        chk({tag, ".cnt"}, {30'd0, counter}, 32'(idx % 4));
        chk({tag, ".fst"}, {31'd0, fstorsnd}, 32'(idx >= 4));
        chk({tag, ".done"}, {31'd0, done}, 32'(idx == 8));
    endtask

    task automatic wait_ack(output int lat);
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (load_ack === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic press_load(input logic [7:0] v, input string tag);
        int a0;
        int lat;
        bit take;
        a0   = acks;
        take = (idx < 8);
        sw   = v;
        btn_load = 1'b1;
        if (take) begin
            wait_ack(lat);
            chk({tag, ".lat"}, lat, LAT);
            mb[idx] = v;
            idx++;
        end else begin
            repeat (12) @(negedge clk);
        end
        btn_load = 1'b0;
        repeat (10) @(negedge clk);
        chk({tag, ".acks"}, acks - a0, take ? 1 : 0);
        check_state(tag);
    endtask

    task automatic press_clear(input string tag);
        int a0;
        a0 = acks;
        btn_clear = 1'b1;
        repeat (12) @(negedge clk);
        btn_clear = 1'b0;
        repeat (10) @(negedge clk);
        model_clear();
        chk({tag, ".acks"}, acks - a0, 0);
        check_state(tag);
    endtask

    initial begin
        int a0;
        int lat;
        logic [7:0] seq [8];
        logic [7:0] v;

        rst       = 1'b1;
        sw        = 8'h00;
        btn_load  = 1'b0;
        btn_clear = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.ack", {31'd0, load_ack}, 0);
        check_state("rst");
        rst = 1'b0;
        repeat (3) @(negedge clk);

        seq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        for (int i = 0; i < 8; i++) press_load(seq[i], $sformatf("ld%0d", i));
        chk("ld.op1", operand1, 32'h44332211);
        chk("ld.op2", operand2, 32'h88776655);

        press_load(8'hFF, "done_ld");

        press_clear("clr1");

        // Bouncing press: only the final steady level may register.
        a0 = acks;
        sw = 8'h5C;
        for (int i = 0; i < 10; i++) begin
            btn_load = ~btn_load;
            repeat (2) @(negedge clk);
        end
        btn_load = 1'b1;
        repeat (10) @(negedge clk);
        btn_load = 1'b0;
        repeat (10) @(negedge clk);
        mb[idx] = 8'h5C;
        idx++;
        chk("bounce.acks", acks - a0, 1);
        check_state("bounce");

        press_clear("clr2");
        press_load(8'hAA, "ab0");
        press_load(8'hBB, "ab1");

        a0 = acks;
        sw = 8'hCC;
        btn_load  = 1'b1;
        btn_clear = 1'b1;
        repeat (12) @(negedge clk);
        btn_load  = 1'b0;
        btn_clear = 1'b0;
        repeat (10) @(negedge clk);
        model_clear();
        chk("both.acks", acks - a0, 0);
        check_state("both");

        press_load(8'h01, "pre0");
        a0 = acks;
        sw = 8'h5A;
        btn_load = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        model_clear();
        chk("midrst.acks", acks - a0, 0);
        chk("midrst.ack", {31'd0, load_ack}, 0);
        check_state("midrst");
        rst = 1'b0;
        wait_ack(lat);
        chk("midrst.lat", lat, LAT);
        mb[idx] = 8'h5A;
        idx++;
        btn_load = 1'b0;
        repeat (10) @(negedge clk);
        chk("midrst.acks2", acks - a0, 1);
        check_state("midrst2");

        press_clear("clr3");
        for (int i = 0; i < 8; i++) begin
            v = 8'($urandom_range(0, 255));
            press_load(v, $sformatf("rnd%0d", i));
        end
        v = 8'($urandom_range(0, 255));
        press_load(v, "rnd_done");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
